// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - Stop/NoStop bit values and the 6-bit stall bus type
//   - canned stall patterns for each hazard source
//   - controller state encodings
// No ports (package).
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

   localparam int STALL_W = 6;

   // A stage register holds when its bit is STOP; it emits a bubble when its
   // bit is STOP and the next-younger stage's bit is NO_STOP.
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   typedef logic [STALL_W-1:0] stall_bus_t;

   // Bit order: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB
   localparam stall_bus_t STALL_NONE   = 6'b000000;
   localparam stall_bus_t STALL_MEMBUS = 6'b000011; // fetch blocked by MEM on RAM
   localparam stall_bus_t STALL_ID     = 6'b000111; // load-use: bubble into EX
   localparam stall_bus_t STALL_EX     = 6'b001111; // multi-cycle EX: bubble into MEM
   localparam stall_bus_t STALL_SLOW   = 6'b011111; // slow device: bubble into WB

   typedef enum logic [0:0] {
      CTRL_RUN  = 1'b0,
      CTRL_WAIT = 1'b1
   } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_stall_prio.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_stall_prio
// Purely combinational priority encoder for the per-cycle hazard requests.
// The deepest stalling stage wins, since its pattern covers the others.
// Ports:
//   stallreq_ex  in   EX needs another cycle (highest priority)
//   stallreq_id  in   load-use hazard in ID
//   memreq_i     in   MEM owns the shared RAM, fetch blocked (lowest)
//   prio_o       out  6-bit stall pattern selected from the above
// -----------------------------------------------------------------------------
module pipeline_ctrl_stall_prio
   import pipeline_ctrl_pkg::*;
(
   input  logic       stallreq_ex,
   input  logic       stallreq_id,
   input  logic       memreq_i,
   output logic [5:0] prio_o
);

   always_comb begin
      if (stallreq_ex)      prio_o = STALL_EX;
      else if (stallreq_id) prio_o = STALL_ID;
      else if (memreq_i)    prio_o = STALL_MEMBUS;
      else                  prio_o = STALL_NONE;
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Combines hazard
// requests into the stall vector and owns the slow-device wait FSM, which
// freezes everything up to MEM/WB until the device answers or a timeout
// forces release.
// Ports:
//   clk           in   system clock, all state on posedge
//   rst           in   asynchronous, active-high reset
//   stallreq_id   in   load-use hazard in ID
//   stallreq_ex   in   EX multi-cycle op in progress
//   memreq_i      in   MEM uses shared RAM this cycle
//   slow_start_i  in   1-cycle pulse: MEM starts a slow-device access
//   slow_done_i   in   slow device delivered/accepted data
//   flush_req_i   in   exception/interrupt flush
//   stall_o       out  [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB, 1=Stop
//   flush_o       out  flush all stage registers this cycle
//   timeout_o     out  1-cycle pulse after a slow access is abandoned
//   wait_cnt_o    out  cycles spent in the current slow wait (0 outside WAIT)
// -----------------------------------------------------------------------------
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 64,
   parameter int WAIT_W     = $clog2(WAIT_LIMIT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_id,
   input  logic              stallreq_ex,
   input  logic              memreq_i,
   input  logic              slow_start_i,
   input  logic              slow_done_i,
   input  logic              flush_req_i,
   output logic [5:0]        stall_o,
   output logic              flush_o,
   output logic              timeout_o,
   output logic [WAIT_W-1:0] wait_cnt_o
);

   localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(WAIT_LIMIT);

   ctrl_state_t       state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic              timeout_q, timeout_d;

   stall_bus_t        prio;
   stall_bus_t        stall_c;
   logic              flush_c;

   pipeline_ctrl_stall_prio u_stall_prio (
      .stallreq_ex (stallreq_ex),
      .stallreq_id (stallreq_id),
      .memreq_i    (memreq_i),
      .prio_o      (prio)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      stall_c   = STALL_NONE;
      flush_c   = 1'b0;

      unique case (state_q)
         CTRL_RUN: begin
            // Flush outranks a slow start issued in the same cycle; the
            // access belongs to an instruction that is being squashed.
            if (flush_req_i) begin
               flush_c = 1'b1;
            end else if (slow_start_i) begin
               stall_c = STALL_SLOW;
               state_d = CTRL_WAIT;
               cnt_d   = WAIT_W'(1);
            end else begin
               stall_c = prio;
            end
         end

         CTRL_WAIT: begin
            stall_c = STALL_SLOW;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;

            if (flush_req_i) begin
               flush_c = 1'b1;
               stall_c = STALL_NONE;
               state_d = CTRL_RUN;
               cnt_d   = '0;
            end else if (slow_done_i) begin
               // Release cycle: ordinary hazards apply again, but a new slow
               // start here is not honoured.
               stall_c = prio;
               state_d = CTRL_RUN;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               stall_c   = prio;
               timeout_d = 1'b1;
               state_d   = CTRL_RUN;
               cnt_d     = '0;
            end
         end

         default: begin
            state_d = CTRL_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge value regardless of statement order.
      if (rst) begin
         state_q   <= CTRL_RUN;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Outputs are combinational from state and requests; rst gates them so the
   // pipeline sees no stall or flush for the whole reset interval.
   assign stall_o    = rst ? STALL_NONE : stall_c;
   assign flush_o    = rst ? 1'b0 : flush_c;
   assign timeout_o  = timeout_q;
   assign wait_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl with WAIT_LIMIT = 8.
// Table-driven combinational RUN cases followed by hand-written multi-cycle
// sequences; expected results go through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

   localparam int LIMIT = 8;
   localparam int CW    = 4;

   logic          clk;
   logic          rst;
   logic          stallreq_id, stallreq_ex, memreq_i;
   logic          slow_start_i, slow_done_i, flush_req_i;
   logic [5:0]    stall_o;
   logic          flush_o;
   logic          timeout_o;
   logic [CW-1:0] wait_cnt_o;

   pipeline_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .memreq_i     (memreq_i),
      .slow_start_i (slow_start_i),
      .slow_done_i  (slow_done_i),
      .flush_req_i  (flush_req_i),
      .stall_o      (stall_o),
      .flush_o      (flush_o),
      .timeout_o    (timeout_o),
      .wait_cnt_o   (wait_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic ex;
      logic id;
      logic mem;
      logic start;
      logic done;
      logic flush;
   } in_t;

   typedef struct {
      string      name;
      in_t        in;
      logic [5:0] stall;
      logic       flush;
   } vec_t;

   typedef struct {
      string         name;
      logic [5:0]    stall;
      logic          flush;
      logic [CW-1:0] cnt;
      logic          timeout;
   } exp_t;

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_MEM  = 6'b000011;
   localparam logic [5:0] S_ID   = 6'b000111;
   localparam logic [5:0] S_EX   = 6'b001111;
   localparam logic [5:0] S_SLOW = 6'b011111;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];

   function automatic in_t mk(input logic ex, id, mem, start, done, flush);
      in_t r;
      r.ex = ex; r.id = id; r.mem = mem;
      r.start = start; r.done = done; r.flush = flush;
      return r;
   endfunction

   task automatic drive(input in_t in);
      stallreq_ex  = in.ex;
      stallreq_id  = in.id;
      memreq_i     = in.mem;
      slow_start_i = in.start;
      slow_done_i  = in.done;
      flush_req_i  = in.flush;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Entered just after a posedge: drive, queue the expectation, compare on
   // the falling edge, then move to just after the next posedge.
   task automatic step(input in_t in, input logic [5:0] es, input logic ef,
                       input int ec, input logic et, input string name);
      exp_t e;
      drive(in);
      sb_q.push_back('{name, es, ef, CW'(ec), et});
      @(negedge clk);
      e = sb_q.pop_front();
      check({e.name, ".stall"},   32'(stall_o),    32'(e.stall));
      check({e.name, ".flush"},   32'(flush_o),    32'(e.flush));
      check({e.name, ".cnt"},     32'(wait_cnt_o), 32'(e.cnt));
      check({e.name, ".timeout"}, 32'(timeout_o),  32'(e.timeout));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      in_t  idle;
      idle = mk(0, 0, 0, 0, 0, 0);

      vecs[0] = '{"run_none",       mk(0, 0, 0, 0, 0, 0), S_NONE, 1'b0};
      vecs[1] = '{"run_mem",        mk(0, 0, 1, 0, 0, 0), S_MEM,  1'b0};
      vecs[2] = '{"run_mem_id",     mk(0, 1, 1, 0, 0, 0), S_ID,   1'b0};
      vecs[3] = '{"run_all3",       mk(1, 1, 1, 0, 0, 0), S_EX,   1'b0};
      vecs[4] = '{"run_ex",         mk(1, 0, 0, 0, 0, 0), S_EX,   1'b0};
      vecs[5] = '{"run_id",         mk(0, 1, 0, 0, 0, 0), S_ID,   1'b0};
      vecs[6] = '{"run_flush_ex",   mk(1, 0, 1, 0, 0, 1), S_NONE, 1'b1};
      vecs[7] = '{"run_done_ign",   mk(0, 0, 1, 0, 1, 0), S_MEM,  1'b0};

      // Reset with requests active: outputs must stay quiet.
      rst = 1'b1;
      drive(mk(1, 1, 1, 1, 0, 1));
      @(negedge clk);
      check("rst.stall",   32'(stall_o),    32'(S_NONE));
      check("rst.flush",   32'(flush_o),    32'h0);
      check("rst.cnt",     32'(wait_cnt_o), 32'h0);
      check("rst.timeout", 32'(timeout_o),  32'h0);
      drive(idle);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Combinational RUN behaviour.
      for (int i = 0; i < 8; i++)
         step(vecs[i].in, vecs[i].stall, vecs[i].flush, 0, 1'b0, vecs[i].name);

      // Slow access answered after 5 cycles; starts/hazards in WAIT ignored.
      step(mk(0, 0, 0, 1, 0, 0), S_SLOW, 0, 0, 0, "t2_start");
      step(idle,                 S_SLOW, 0, 1, 0, "t2_w1");
      step(mk(0, 0, 0, 1, 0, 0), S_SLOW, 0, 2, 0, "t2_w2_start_ign");
      step(mk(1, 0, 1, 0, 0, 0), S_SLOW, 0, 3, 0, "t2_w3_hazard");
      step(idle,                 S_SLOW, 0, 4, 0, "t2_w4");
      step(mk(0, 0, 0, 0, 1, 0), S_NONE, 0, 5, 0, "t2_done");
      step(idle,                 S_NONE, 0, 0, 0, "t2_after");

      // Release with a pending hazard and a start that must not re-enter WAIT.
      step(mk(0, 0, 0, 1, 0, 0), S_SLOW, 0, 0, 0, "t2b_start");
      step(mk(0, 0, 1, 1, 1, 0), S_MEM,  0, 1, 0, "t2b_done_mem");
      step(mk(0, 1, 0, 0, 0, 0), S_ID,   0, 0, 0, "t2b_run_id");

      // Timeout at WAIT_LIMIT.
      step(mk(0, 0, 0, 1, 0, 0), S_SLOW, 0, 0, 0, "t3_start");
      for (int i = 1; i < LIMIT; i++)
         step(idle, S_SLOW, 0, i, 0, $sformatf("t3_w%0d", i));
      step(idle, S_NONE, 0, LIMIT, 0, "t3_release");
      step(idle, S_NONE, 0, 0, 1, "t3_timeout_pulse");
      step(idle, S_NONE, 0, 0, 0, "t3_pulse_end");

      // Done on the limit cycle wins over timeout; release carries P.
      step(mk(0, 0, 0, 1, 0, 0), S_SLOW, 0, 0, 0, "t3b_start");
      for (int i = 1; i < LIMIT; i++)
         step(idle, S_SLOW, 0, i, 0, $sformatf("t3b_w%0d", i));
      step(mk(1, 0, 0, 0, 1, 0), S_EX,   0, LIMIT, 0, "t3b_done_at_limit");
      step(idle,                 S_NONE, 0, 0, 0, "t3b_no_timeout");

      // Flush on the third WAIT cycle aborts the access.
      step(mk(0, 0, 0, 1, 0, 0), S_SLOW, 0, 0, 0, "t4_start");
      step(idle,                 S_SLOW, 0, 1, 0, "t4_w1");
      step(idle,                 S_SLOW, 0, 2, 0, "t4_w2");
      step(mk(1, 0, 0, 0, 0, 1), S_NONE, 1, 3, 0, "t4_flush");
      step(mk(0, 0, 1, 0, 0, 0), S_MEM,  0, 0, 0, "t4_run_after");
      step(idle,                 S_NONE, 0, 0, 0, "t4_no_timeout");

      // Flush + start + EX in RUN: flush only, remain in RUN.
      step(mk(1, 0, 0, 1, 0, 1), S_NONE, 1, 0, 0, "t5_flush_start_ex");
      step(mk(0, 0, 1, 0, 0, 0), S_MEM,  0, 0, 0, "t5_still_run");

      // Asynchronous reset between edges mid-WAIT.
      step(mk(0, 0, 0, 1, 0, 0), S_SLOW, 0, 0, 0, "t6_start");
      step(idle,                 S_SLOW, 0, 1, 0, "t6_w1");
      step(idle,                 S_SLOW, 0, 2, 0, "t6_w2");
      drive(mk(0, 0, 1, 0, 0, 0));
      #2;
      rst = 1'b1;
      #1;
      check("t6_async.stall", 32'(stall_o),    32'(S_NONE));
      check("t6_async.flush", 32'(flush_o),    32'h0);
      check("t6_async.cnt",   32'(wait_cnt_o), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(idle);
      @(posedge clk);
      #1;
      step(mk(0, 0, 1, 0, 0, 0), S_MEM,  0, 0, 0, "t6_run_after");
      step(idle,                 S_NONE, 0, 0, 0, "t6_no_timeout");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
